shifter_multistep: RTL

Iterative barrel-less shifter for the soft-processor execute stage: a parametrised successor to the single-bit iterative shifter. Each busy cycle shifts by up to STEP bit positions, giving a tunable trade between area and latency. Adds an optional rotate mode. Uses the same start/stalled/dst pipeline handshake, so it drops into the same execute slot.

---
 rtl/shifter_multistep.sv | 134 +++++++++++++
 1 files changed

// File: rtl/shifter_multistep.sv
// Iterative shifter that moves up to STEP bit positions per busy cycle. It uses the start/stalled/dst execute handshake.
// Optional rotate mode (ROR/ROL) is built only when SHIFTER_MULTISTEP_ROTATE_EN is defined.
module shifter_multistep #(
    parameter int WIDTH    = 32,
    parameter int SA_WIDTH = 5,
    parameter int STEP     = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WIDTH-1:0]    opB,
    input  logic [SA_WIDTH-1:0] sa,
    input  logic [2:0]          op,
    input  logic                start,
    input  logic [4:0]          dst,
    output logic                stalled,
    output logic [WIDTH-1:0]    result
);

    // One extra bit so that STEP == WIDTH == 2**SA_WIDTH is still representable.
    localparam logic [SA_WIDTH:0] STEP_W = (SA_WIDTH+1)'(STEP);

    logic                busy_q,  busy_d;
    logic [SA_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0]    shreg_q, shreg_d;
    logic                dir_q,   dir_d;
    logic                sext_q,  sext_d;
    logic                rot_q;
    logic                stall_q;

    logic                nop;
    logic                accept;
    logic [SA_WIDTH:0]   count_ext;
    logic [SA_WIDTH:0]   k;
    logic                last_step;
    logic [WIDTH-1:0]    stepped;

    assign nop       = (dst == 5'd0);
    assign accept    = start & ~stall_q & ~nop;
    assign count_ext = {1'b0, count_q};
    assign last_step = (count_ext <= STEP_W);
    assign k         = last_step ? count_ext : STEP_W;

    function automatic logic [WIDTH-1:0] shift1(
        input logic [WIDTH-1:0] v,
        input logic             dir,
        input logic             sext,
        input logic             rot
    );
        logic fill;
        if (dir) begin
            fill = rot ? v[0] : (sext & v[WIDTH-1]);
            return {fill, v[WIDTH-1:1]};
        end else begin
            fill = rot ? v[WIDTH-1] : 1'b0;
            return {v[WIDTH-2:0], fill};
        end
    endfunction

`ifdef SHIFTER_MULTISTEP_ROTATE_EN
    logic rot_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rot_q <= 1'b0;
        else         rot_q <= rot_d;
    end

    always_comb begin
        rot_d = rot_q;
        if (!busy_q && accept) rot_d = op[2];
    end
`else
    logic unused_rot;

    // Without rotate support op[2] is dropped: 101 acts as SRL, 100 as SLL.
    assign rot_q      = 1'b0;
    assign unused_rot = op[2];
`endif

    // A chain of STEP single-bit stages, each enabled while its index is below k.
    always_comb begin
        stepped = shreg_q;
        for (int i = 0; i < STEP; i++) begin
            if ((SA_WIDTH+1)'(i) < k) stepped = shift1(stepped, dir_q, sext_q, rot_q);
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q  <= 1'b0;
            count_q <= '0;
            shreg_q <= '0;
            dir_q   <= 1'b0;
            sext_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
            sext_q  <= sext_d;
            stall_q <= stalled;
        end
    end

    // Next state
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        shreg_d = shreg_q;
        dir_d   = dir_q;
        sext_d  = sext_q;
        if (!busy_q) begin
            if (accept) begin
                shreg_d = opB;
                count_d = sa;
                dir_d   = op[0];
                sext_d  = op[1];
                busy_d  = (sa != '0);
            end
        end else begin
            shreg_d = stepped;
            count_d = count_q - k[SA_WIDTH-1:0];
            if (last_step) busy_d = 1'b0;
        end
    end

    // Outputs
    always_comb begin
        stalled = accept | busy_q;
        result  = shreg_q;
    end

endmodule
